tty: RTL

TTY -- requirements
Module: tty

---
 rtl/tty_pkg.sv | 24 ++
 rtl/tty.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tty_pkg.sv
// Shared constants and state encoding for the text-mode terminal writer.
// Screen geometry defaults, control codes and the controller state enumeration.
package tty_pkg;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 25;
    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        PUT_CHR,
        PUT_ATR,
        SCR_RD,
        SCR_WR,
        FILL,
        CLEAR
    } state_t;

endpackage

// File: rtl/tty.sv
// Terminal character writer: turns a byte stream into char/attr writes to video RAM,
// handling CR/LF/BS/FF, scrolling by copying rows up and blanking the last row.
module tty #(
    parameter int         COLS  = tty_pkg::COLS,
    parameter int         ROWS  = tty_pkg::ROWS,
    parameter logic [7:0] BLANK = tty_pkg::BLANK
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    input  logic [7:0]  in_attr,
    output logic        in_ready,
    output logic [11:0] address,
    output logic [7:0]  wdata,
    output logic        we,
    input  logic [7:0]  rdata,
    output logic [10:0] cursor
);

    import tty_pkg::*;

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [10:0] COLS_C    = 11'(COLS);
    localparam logic [10:0] CELLS_C   = 11'(CELLS);
    localparam logic [10:0] LAST_ROW  = 11'(COLS * (ROWS - 1));
    localparam logic [11:0] ROW_BYTES = 12'(2 * COLS);
    localparam logic [11:0] LAST_BYTE = 12'(2 * CELLS - 1);
    localparam logic [11:0] FILL_BASE = 12'(2 * COLS * (ROWS - 1));

    state_t      state, state_n;
    logic [10:0] cursor_n;
    logic [11:0] ptr, ptr_n;
    logic [7:0]  char_q, attr_q;
    logic [10:0] col;
    logic [10:0] inc;
    logic [11:0] lf_sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cursor <= '0;
            ptr    <= '0;
            char_q <= '0;
            attr_q <= '0;
        end else begin
            state  <= state_n;
            cursor <= cursor_n;
            ptr    <= ptr_n;
            if (in_ready && in_valid) begin
                char_q <= in_char;
                attr_q <= in_attr;
            end
        end
    end

    // PUT_CHR doubles as the decode cycle for control codes, so every
    // accepted byte holds in_ready low for at least one cycle.
    always_comb begin
        state_n  = state;
        cursor_n = cursor;
        ptr_n    = ptr;
        address  = '0;
        wdata    = '0;
        we       = 1'b0;
        in_ready = 1'b0;
        col      = cursor % COLS_C;
        inc      = cursor + 11'd1;
        lf_sum   = {1'b0, cursor} + {1'b0, COLS_C};

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = PUT_CHR;
            end
            PUT_CHR: begin
                if (char_q >= 8'h20) begin
                    address = {cursor, 1'b0};
                    wdata   = char_q;
                    we      = 1'b1;
                    state_n = PUT_ATR;
                end else begin
                    state_n = IDLE;
                    case (char_q)
                        CR: cursor_n = cursor - col;
                        LF: begin
                            if (lf_sum >= {1'b0, CELLS_C}) begin
                                cursor_n = LAST_ROW + col;
                                ptr_n    = ROW_BYTES;
                                state_n  = SCR_RD;
                            end else begin
                                cursor_n = lf_sum[10:0];
                            end
                        end
                        BS: if (cursor != 11'd0) cursor_n = cursor - 11'd1;
                        FF: begin
                            ptr_n   = '0;
                            state_n = CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            PUT_ATR: begin
                address = {cursor, 1'b1};
                wdata   = attr_q;
                we      = 1'b1;
                if (inc == CELLS_C) begin
                    cursor_n = LAST_ROW;
                    ptr_n    = ROW_BYTES;
                    state_n  = SCR_RD;
                end else begin
                    cursor_n = inc;
                    state_n  = IDLE;
                end
            end
            SCR_RD: begin
                address = ptr;
                state_n = SCR_WR;
            end
            // rdata now carries the byte addressed during SCR_RD.
            SCR_WR: begin
                address = ptr - ROW_BYTES;
                wdata   = rdata;
                we      = 1'b1;
                if (ptr == LAST_BYTE) begin
                    ptr_n   = FILL_BASE;
                    state_n = FILL;
                end else begin
                    ptr_n   = ptr + 12'd1;
                    state_n = SCR_RD;
                end
            end
            FILL: begin
                address = ptr;
                wdata   = ptr[0] ? attr_q : BLANK;
                we      = 1'b1;
                if (ptr == LAST_BYTE) state_n = IDLE;
                else                  ptr_n   = ptr + 12'd1;
            end
            CLEAR: begin
                address = ptr;
                wdata   = ptr[0] ? attr_q : BLANK;
                we      = 1'b1;
                if (ptr == LAST_BYTE) begin
                    cursor_n = '0;
                    state_n  = IDLE;
                end else begin
                    ptr_n = ptr + 12'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
